// File: rtl/urv_loader_pkg.sv
// Shared definitions for the IRAM host loader: command/response codes,
// FSM state encoding and the RAM word-address helper.
package urv_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;

  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_DATA      = 4'd2,
    ST_WR        = 4'd3,
    ST_RD_ISSUE  = 4'd4,
    ST_RD_WAIT   = 4'd5,
    ST_VRD_ISSUE = 4'd6,
    ST_VRD_WAIT  = 4'd7,
    ST_TX        = 4'd8
  } state_e;

  // Byte address folded into the RAM (power-of-two size) and forced word-aligned.
  function automatic logic [31:0] word_addr(input logic [31:0] addr, input logic [31:0] size);
    return addr & (size - 32'd1) & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/urv_iram_loader_if.sv
// Host byte link, IRAM port-b and core-reset signals of the loader,
// bundled with a loader-side (master) and environment-side (slave) view.
interface urv_iram_loader_if;

  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        enb_o;
  logic        web_o;
  logic [31:0] ab_o;
  logic [3:0]  bweb_o;
  logic [31:0] db_o;
  logic [31:0] qb_i;
  logic        cpu_rst_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, qb_i,
    output rx_ready_o, tx_data_o, tx_valid_o, enb_o, web_o, ab_o, bweb_o, db_o, cpu_rst_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, qb_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, enb_o, web_o, ab_o, bweb_o, db_o, cpu_rst_o
  );

endinterface

// File: rtl/urv_iram_loader.sv
// Framed host-command loader for IRAM port b; holds the core in reset until RUN.
// Define URV_IRAM_LOADER_VERIFY_EN to read back every write and answer ACK/NAK.
module urv_iram_loader
  import urv_loader_pkg::*;
#(
  parameter int unsigned g_size           = 65536,
  parameter int unsigned g_timeout_cycles = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  urv_iram_loader_if.master bus
);

  localparam int unsigned      TO_W    = $clog2(g_timeout_cycles + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(g_timeout_cycles - 1);
  localparam logic [31:0]      SIZE    = 32'(g_size);

  state_e          state_q,   state_d;
  logic [1:0]      cnt_q,     cnt_d;
  logic [7:0]      cmd_q,     cmd_d;
  logic [31:0]     addr_q,    addr_d;
  logic [31:0]     data_q,    data_d;
  logic [31:0]     rsp_q,     rsp_d;
  logic [1:0]      tx_left_q, tx_left_d;
  logic [TO_W-1:0] timeout_q, timeout_d;

  logic            rx_ready_q, rx_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            enb_q,      enb_d;
  logic            web_q,      web_d;
  logic [3:0]      bweb_q,     bweb_d;
  logic [31:0]     ab_q,       ab_d;
  logic [31:0]     db_q,       db_d;
  logic            cpu_rst_q,  cpu_rst_d;

  logic            rx_acc;
  logic            tx_acc;
  logic [31:0]     addr_shift;
  logic [31:0]     data_shift;

  assign rx_acc     = bus.rx_valid_i & rx_ready_q;
  assign tx_acc     = tx_valid_q & bus.tx_ready_i;
  assign addr_shift = {addr_q[23:0], bus.rx_data_i};
  assign data_shift = {data_q[23:0], bus.rx_data_i};

  // Next-state and next-output logic; RAM strobes default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rsp_d     = rsp_q;
    tx_left_d = tx_left_q;
    timeout_d = timeout_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    enb_d      = 1'b0;
    web_d      = 1'b0;
    bweb_d     = 4'h0;
    ab_d       = ab_q;
    db_d       = db_q;
    cpu_rst_d  = cpu_rst_q;

    case (state_q)
      ST_IDLE: begin
        timeout_d = '0;
        if (rx_acc) begin
          cnt_d = 2'd0;
          cmd_d = bus.rx_data_i;
          case (bus.rx_data_i)
            CMD_WRITE, CMD_READ: state_d = ST_ADDR;
            CMD_RUN:             cpu_rst_d = 1'b0;
            CMD_HALT:            cpu_rst_d = 1'b1;
            default: begin
              rsp_d      = {RSP_NAK, 24'h00_0000};
              tx_data_d  = RSP_NAK;
              tx_valid_d = 1'b1;
              tx_left_d  = 2'd0;
              state_d    = ST_TX;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (rx_acc) begin
          timeout_d = '0;
          addr_d    = addr_shift;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (cmd_q == CMD_WRITE) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_RD_ISSUE;
              enb_d   = 1'b1;
              ab_d    = word_addr(addr_shift, SIZE);
            end
          end else begin
            state_d = ST_ADDR;
          end
        end else if (timeout_q == TO_LAST) begin
          timeout_d = '0;
          state_d   = ST_IDLE;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      ST_DATA: begin
        if (rx_acc) begin
          timeout_d = '0;
          data_d    = data_shift;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_WR;
            enb_d   = 1'b1;
            web_d   = 1'b1;
            bweb_d  = 4'hF;
            ab_d    = word_addr(addr_q, SIZE);
            db_d    = data_shift;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_q == TO_LAST) begin
          timeout_d = '0;
          state_d   = ST_IDLE;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

`ifdef URV_IRAM_LOADER_VERIFY_EN
      ST_WR: begin
        state_d = ST_VRD_ISSUE;
        enb_d   = 1'b1;
      end

      ST_VRD_ISSUE: state_d = ST_VRD_WAIT;

      ST_VRD_WAIT: begin
        if (bus.qb_i == db_q) begin
          rsp_d     = {RSP_ACK, 24'h00_0000};
          tx_data_d = RSP_ACK;
        end else begin
          rsp_d     = {RSP_NAK, 24'h00_0000};
          tx_data_d = RSP_NAK;
        end
        tx_valid_d = 1'b1;
        tx_left_d  = 2'd0;
        state_d    = ST_TX;
      end
`else
      ST_WR: state_d = ST_IDLE;
`endif

      ST_RD_ISSUE: state_d = ST_RD_WAIT;

      ST_RD_WAIT: begin
        rsp_d      = bus.qb_i;
        tx_data_d  = bus.qb_i[31:24];
        tx_valid_d = 1'b1;
        tx_left_d  = 2'd3;
        state_d    = ST_TX;
      end

      // Response register shifts left so the next byte is always in [31:24].
      ST_TX: begin
        if (tx_acc) begin
          if (tx_left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            rsp_d     = {rsp_q[23:0], 8'h00};
            tx_data_d = rsp_q[23:16];
            tx_left_d = tx_left_q - 2'd1;
          end
        end else begin
          state_d = ST_TX;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      cmd_q      <= 8'h00;
      addr_q     <= 32'h0000_0000;
      data_q     <= 32'h0000_0000;
      rsp_q      <= 32'h0000_0000;
      tx_left_q  <= 2'd0;
      timeout_q  <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      enb_q      <= 1'b0;
      web_q      <= 1'b0;
      bweb_q     <= 4'h0;
      ab_q       <= 32'h0000_0000;
      db_q       <= 32'h0000_0000;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_q      <= rsp_d;
      tx_left_q  <= tx_left_d;
      timeout_q  <= timeout_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      enb_q      <= enb_d;
      web_q      <= web_d;
      bweb_q     <= bweb_d;
      ab_q       <= ab_d;
      db_q       <= db_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign bus.rx_ready_o = rx_ready_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.enb_o      = enb_q;
  assign bus.web_o      = web_q;
  assign bus.bweb_o     = bweb_q;
  assign bus.ab_o       = ab_q;
  assign bus.db_o       = db_q;
  assign bus.cpu_rst_o  = cpu_rst_q;

endmodule

// File: tb/tb_urv_iram_loader.sv
// Scoreboard bench for urv_iram_loader: directed host frames, a behavioural
// IRAM on port b, and a negedge monitor checking TX bytes and RAM write strobes.
module tb_urv_iram_loader;

  localparam int unsigned TO = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  urv_iram_loader_if bus ();

  urv_iram_loader #(
    .g_size           (65536),
    .g_timeout_cycles (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_tx[$];
  logic [67:0] exp_wr[$];

  logic        tx_toggle;
  logic        tx_hold;
  logic [31:0] qb_xor;
  logic [31:0] mem [0:16383];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural IRAM port b: registered read, optional read corruption.
  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (bus.enb_o) begin
      if (bus.web_o) mem[bus.ab_o[15:2]] <= bus.db_o;
      else           bus.qb_i <= mem[bus.ab_o[15:2]] ^ qb_xor;
    end
  end

  // Drive tx_ready, then score the handshakes that the coming posedge will complete.
  always @(negedge clk) begin
    if (tx_hold)        bus.tx_ready_i = 1'b0;
    else if (tx_toggle) bus.tx_ready_i = ~bus.tx_ready_i;
    else                bus.tx_ready_i = 1'b1;
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      if (exp_tx.size() == 0) check("tx_unexpected", {60'h0, bus.tx_data_o}, 68'h0);
      else                    check("tx_byte", {60'h0, bus.tx_data_o}, {60'h0, exp_tx.pop_front()});
    end
    if (bus.enb_o && bus.web_o) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {bus.bweb_o, bus.ab_o, bus.db_o}, 68'h0);
      else                    check("wr_strobe", {bus.bweb_o, bus.ab_o, bus.db_o}, exp_wr.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400 && !(exp_tx.size() == 0 && exp_wr.size() == 0 &&
                        bus.rx_ready_o && !bus.tx_valid_o)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got %0d tx / %0d wr pending expected 0", exp_tx.size(), exp_wr.size());
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_ab,
                          input logic [31:0] data, input logic [7:0] exp_rsp);
    exp_wr.push_back({4'hF, exp_ab, data});
`ifdef URV_IRAM_LOADER_VERIFY_EN
    exp_tx.push_back(exp_rsp);
`endif
    send_byte(8'h01);
    send_word(addr);
    send_word(data);
    check("wr_latency", {66'h0, bus.enb_o, bus.web_o}, 68'h3);
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data);
    logic [2:0] seen;
    exp_tx.push_back(data[31:24]);
    exp_tx.push_back(data[23:16]);
    exp_tx.push_back(data[15:8]);
    exp_tx.push_back(data[7:0]);
    send_byte(8'h02);
    send_word(addr);
    seen[2] = bus.tx_valid_o;
    @(posedge clk); #1;
    seen[1] = bus.tx_valid_o;
    @(posedge clk); #1;
    seen[0] = bus.tx_valid_o;
    check("rd_latency", {65'h0, seen}, 68'h1);
    wait_idle();
  endtask

  initial begin
    rst            = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    tx_toggle      = 1'b0;
    tx_hold        = 1'b0;
    qb_xor         = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {67'h0, bus.rx_ready_o}, 68'h0);
    check("rst_cpu_rst", {67'h0, bus.cpu_rst_o}, 68'h1);
    check("rst_tx", {59'h0, bus.tx_valid_o, bus.tx_data_o}, 68'h0);
    check("rst_ram", {bus.bweb_o, bus.ab_o, bus.db_o}, 68'h0);
    check("rst_strobe", {66'h0, bus.enb_o, bus.web_o}, 68'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {67'h0, bus.rx_ready_o}, 68'h1);

    do_write(32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF, 8'h06);
    check("cpu_rst_after_wr", {67'h0, bus.cpu_rst_o}, 68'h1);
    tx_toggle = 1'b1;
    do_read(32'h0000_0100, 32'hDEAD_BEEF);
    tx_toggle = 1'b0;

    do_write(32'h0001_0007, 32'h0000_0004, 32'hCAFE_F00D, 8'h06);
    do_read(32'h0000_0004, 32'hCAFE_F00D);

    send_byte(8'h03);
    check("run_cpu_rst", {67'h0, bus.cpu_rst_o}, 68'h0);
    send_byte(8'h04);
    check("halt_cpu_rst", {67'h0, bus.cpu_rst_o}, 68'h1);

    exp_tx.push_back(8'h15);
    send_byte(8'h7F);
    wait_idle();

    // Response held off well past the timeout must still be delivered.
    tx_hold = 1'b1;
    exp_tx.push_back(8'h15);
    send_byte(8'h00);
    repeat (TO + 10) @(negedge clk);
    check("tx_no_timeout", {67'h0, bus.tx_valid_o}, 68'h1);
    tx_hold = 1'b0;
    wait_idle();

    // Abandoned frame: stall mid-address, then a full frame must parse cleanly.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TO + 10) @(negedge clk);
    do_write(32'h0000_0200, 32'h0000_0200, 32'h1234_5678, 8'h06);
    do_read(32'h0000_0200, 32'h1234_5678);

    // Reset in the middle of the data bytes.
    send_byte(8'h03);
    send_byte(8'h01);
    send_word(32'h0000_0300);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cpu_rst", {67'h0, bus.cpu_rst_o}, 68'h1);
    check("midrst_ready", {67'h0, bus.rx_ready_o}, 68'h0);
    rst = 1'b0;
    do_write(32'h0000_0300, 32'h0000_0300, 32'h0BAD_F00D, 8'h06);
    do_read(32'h0000_0300, 32'h0BAD_F00D);

`ifdef URV_IRAM_LOADER_VERIFY_EN
    qb_xor = 32'h0000_0100;
    do_write(32'h0000_0400, 32'h0000_0400, 32'h5555_AAAA, 8'h15);
    qb_xor = 32'h0;
    do_write(32'h0000_0404, 32'h0000_0404, 32'h0F0F_F0F0, 8'h06);
`endif

    wait_idle();
    repeat (5) @(negedge clk);
    check("queues_drained", {4'h0, 32'(exp_tx.size()), 32'(exp_wr.size())}, 68'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/urv_iram_loader.md
# urv_iram_loader

Host-side initiator for the IRAM's second port: accepts a byte stream of framed commands from a host link (UART or debug bridge) and converts it into word writes and reads on the `b` port of the dual-port instruction RAM. It also holds the core in reset until the host issues a run command, so firmware can be loaded after bitstream configuration. Sits between the host byte transport and the `b` port of `urv_iram`; the core keeps exclusive use of port `a`.

## Interface
- `g_size`, 65536: IRAM size in bytes; power of two; RAM addresses wrap modulo `g_size`.
- `g_timeout_cycles`, 1000000: maximum idle cycles between bytes of one frame before the frame is abandoned; must be ≥ 1.
- `clk_i` in 1: the single clock for the whole block.
- `rst_i` in 1: reset; synchronous, active-high.
- `rx_data_i` in 8: incoming host byte.
- `rx_valid_i` in 1: `rx_data_i` is valid.
- `rx_ready_o` out 1: the loader accepts a byte.
- `tx_data_o` out 8: response byte to the host.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: the host side accepts the response byte.
- `enb_o` out 1: RAM port `b` enable.
- `web_o` out 1: RAM port `b` write enable.
- `ab_o` out 32: RAM port `b` byte address; always word-aligned.
- `bweb_o` out 4: RAM port `b` byte write enables.
- `db_o` out 32: RAM port `b` write data.
- `qb_i` in 32: RAM port `b` read data; valid one cycle after a read enable.
- `cpu_rst_o` out 1: core reset request, active-high.

## Operation
- Byte transfer: a byte moves on `rx_valid_i & rx_ready_o`, and likewise on `tx_valid_o & tx_ready_i`.
- Frame format: one command byte, then 4 address bytes (MSB first), then 4 data bytes (MSB first), the data bytes for WRITE only.
- Commands:
  - 0x01 WRITE: 9-byte frame.
  - 0x02 READ: 5-byte frame.
  - 0x03 RUN: 1 byte.
  - 0x04 HALT: 1 byte.
  - Any other command byte: transmit NAK 0x15 and return to IDLE.
- Address handling: `ab_o = addr & (g_size-1) & ~32'h3`. Low two address bits are ignored; addresses beyond `g_size` wrap.
- States:
  - IDLE: `rx_ready_o` high.
  - ADDR: 4 bytes.
  - DATA: 4 bytes.
  - WR: one cycle.
  - RD_ISSUE, then RD_WAIT.
  - TX: send 1 or 4 bytes.
- WRITE: IDLE→ADDR→DATA→WR; WR drives `enb_o=web_o=1`, `bweb_o=4'hF`, `db_o=data` for exactly one cycle.
- READ: IDLE→ADDR→RD_ISSUE→RD_WAIT→TX.
  - RD_ISSUE: `enb_o=1`, `web_o=0`.
  - RD_WAIT: capture `qb_i` into the response register.
  - TX: send the 4 bytes MSB first, each held until accepted, then return to IDLE.
- RUN: `cpu_rst_o` falls one cycle after the command byte is accepted. HALT: `cpu_rst_o` rises one cycle after. Neither sends a response. Both are accepted in any `cpu_rst_o` state.
- Timeout: a counter is cleared on every accepted byte and counts in ADDR and DATA only. On reaching `g_timeout_cycles` the frame is discarded silently and the state returns to IDLE. The timeout never fires in TX or RD states.
- `rx_ready_o` is low in WR, RD_*, and TX; there is no pipelining of frames.
- `enb_o` is high only in WR and RD_ISSUE (plus VRD_ISSUE when verify is configured); `web_o` is high only in WR.
- The loader does not arbitrate with the core. Writes while `cpu_rst_o=0` are legal; the host is responsible for coherence.

## Timing
- Reset values:
  - `cpu_rst_o=1`.
  - `rx_ready_o=0` while `rst_i` is high, and 1 in the first cycle after reset.
  - `tx_valid_o=0`, `tx_data_o=0`.
  - `enb_o=web_o=0`, `bweb_o=0`, `ab_o=0`, `db_o=0`.
  - State IDLE; timeout counter 0.
- WRITE: the RAM write occurs the cycle after the 9th byte is accepted.
- READ: the first `tx_valid_o` occurs 3 cycles after the 5th byte is accepted (RD_ISSUE, RD_WAIT, TX).
- Reset mid-frame: the frame is discarded, any pending response is dropped, and `cpu_rst_o` re-asserts.
- Stalls: `rx_valid_i` low mid-frame and `tx_ready_i` low in TX both hold state indefinitely, subject to the timeout rules above.

## Configuration
- `URV_IRAM_LOADER_VERIFY_EN` defined: WR is followed by VRD_ISSUE (read the same address) and VRD_WAIT (compare `qb_i` with `db_o`). TX then sends ACK 0x06 on a match or NAK 0x15 on a mismatch, and the state returns to IDLE.
- Undefined: WRITE sends no response and returns from WR to IDLE directly.

## Structure
- Shared package `urv_loader_pkg`:
  - Command codes: `CMD_WRITE=8'h01`, `CMD_READ=8'h02`, `CMD_RUN=8'h03`, `CMD_HALT=8'h04`.
  - Response codes: `RSP_ACK=8'h06`, `RSP_NAK=8'h15`.
  - State enum.
- Single module; no sub-module. The byte shift/assembly register and the timeout counter are inline.

## Test plan
- Reset, then WRITE 01 00 00 01 00 DE AD BE EF → one-cycle strobe with `ab_o=0x100`, `db_o=0xDEADBEEF`, `bweb_o=F`; `cpu_rst_o` stays 1.
- READ 02 00 00 01 00 after that write → TX bytes DE AD BE EF in order, with `tx_ready_i` toggled every other cycle.
- WRITE to address 0x0001_0007 with `g_size=65536` → `ab_o=0x0004`. READ of 0x0000_0004 returns the written data.
- RUN 03 → `cpu_rst_o` falls one cycle later. HALT 04 → it rises again. Command 0x7F → single TX byte 0x15.
- Send 01 00 00 and then stall `g_timeout_cycles` → return to IDLE with no RAM strobe. A subsequent full WRITE succeeds.
- With `URV_IRAM_LOADER_VERIFY_EN`: a normal write returns 0x06. Forcing a corrupted `qb_i` during VRD_WAIT returns 0x15. Asserting `rst_i` mid-DATA drops the frame and sets `cpu_rst_o=1`.
